// File: rtl/life_engine.sv
// Conway's Game of Life engine (B3/S23): row-serial evaluation into a shadow board,
// then a single-cycle commit that refreshes the per-cell colour codes and counters.
module life_engine #(
    parameter int ROWS = 12,
    parameter int COLS = 12,
    parameter int WRAP = 1
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               step,
    input  logic                               clear,
    input  logic                               edit_en,
    input  logic [3:0]                         edit_row,
    input  logic [3:0]                         edit_col,
    output logic                               busy,
    output logic                               done,
    output logic [ROWS-1:0][COLS-1:0][1:0]     pixiv,
    output logic [15:0]                        generation,
    output logic [7:0]                         population
);

    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        COMMIT
    } state_t;

    state_t                     state;
    logic [RW-1:0]              row_cnt;
    logic [ROWS-1:0][COLS-1:0]  cur;
    logic [ROWS-1:0][COLS-1:0]  nxt;
    logic [COLS-1:0]            row_next;
    logic [7:0]                 nxt_pop;
    logic                       edit_hit;
    logic [RW-1:0]              er;
    logic [CW-1:0]              ec;
    int                         nbr;
    int                         rr;
    int                         cc;
    logic                       nb_ok;

    assign edit_hit = edit_en && (int'(edit_row) < ROWS) && (int'(edit_col) < COLS);
    assign er       = RW'(edit_row);
    assign ec       = CW'(edit_col);

    // Next state of the row selected by row_cnt, read from the current board.
    always_comb begin
        row_next = '0;
        nbr      = 0;
        rr       = 0;
        cc       = 0;
        nb_ok    = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            nbr = 0;
            for (int dr = -1; dr <= 1; dr++) begin
                for (int dc = -1; dc <= 1; dc++) begin
                    rr = int'(row_cnt) + dr;
                    cc = c + dc;
                    if (WRAP != 0) begin
                        rr    = (rr + ROWS) % ROWS;
                        cc    = (cc + COLS) % COLS;
                        nb_ok = 1'b1;
                    end else begin
                        nb_ok = (rr >= 0) && (rr < ROWS) && (cc >= 0) && (cc < COLS);
                    end
                    if (nb_ok && !(dr == 0 && dc == 0) && cur[RW'(rr)][CW'(cc)]) begin
                        nbr = nbr + 1;
                    end
                end
            end
            row_next[c] = (nbr == 3) || (cur[row_cnt][c] && (nbr == 2));
        end
    end

    always_comb begin
        nxt_pop = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                nxt_pop = nxt_pop + 8'(nxt[r][c]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            state      <= IDLE;
            row_cnt    <= '0;
            cur        <= '0;
            nxt        <= '0;
            pixiv      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            generation <= '0;
            population <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (edit_hit) begin
                        cur[er][ec]   <= ~cur[er][ec];
                        pixiv[er][ec] <= cur[er][ec] ? 2'b00 : 2'b11;
                        population    <= cur[er][ec] ? population - 8'd1 : population + 8'd1;
                    end
                    if (step) begin
                        state   <= COMPUTE;
                        row_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                COMPUTE: begin
                    nxt[row_cnt] <= row_next;
                    if (row_cnt == RW'(ROWS - 1)) begin
                        state <= COMMIT;
                    end else begin
                        row_cnt <= row_cnt + RW'(1);
                    end
                end
                COMMIT: begin
                    cur <= nxt;
                    for (int r = 0; r < ROWS; r++) begin
                        for (int c = 0; c < COLS; c++) begin
                            pixiv[r][c] <= {nxt[r][c], cur[r][c]};
                        end
                    end
                    population <= nxt_pop;
                    generation <= generation + 16'd1;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    row_cnt    <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
